// File: rtl/gcm_pkg.sv
// Shared widths, lane encoding and byte-mask helper for the GCM receive packer.
package gcm_pkg;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;
    localparam int LANES   = 4;
    localparam int LANE_W  = 2;

    typedef enum logic [LANE_W-1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } laneT;

    // keep bit i enables byte i of the word (bit3 -> [31:24])
    function automatic logic [WORD_W-1:0] keepMask(input logic [LANES-1:0] keep);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_sync_fifo.sv
// Show-ahead synchronous FIFO; the head is read combinationally and held while empty.
module gcm_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [AW:0]      countReg;
    logic [WIDTH-1:0] lastReg;
    logic             doWrite;
    logic             doRead;

    assign empty   = (countReg == '0);
    assign full    = (countReg == FULL_COUNT);
    assign count   = countReg;
    assign doWrite = wr_en && !full;
    assign doRead  = rd_en && !empty;

    // lastReg keeps the most recently popped block so the output holds when empty
    assign rd_data = empty ? lastReg : mem[rdPtrReg];

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtrReg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
            lastReg  <= '0;
        end else begin
            if (doWrite) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (doRead) begin
                rdPtrReg <= rdPtrReg + 1'b1;
                lastReg  <= mem[rdPtrReg];
            end
            case ({doWrite, doRead})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/gcm_rx_packer.sv
// Packs a 32-bit word stream into zero-padded 128-bit blocks and queues them for the encryptor.
module gcm_rx_packer
    import gcm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WORD_W-1:0]  inData,
    input  logic [LANES-1:0]   inKeep,
    input  logic               inLast,
    output logic               rxEmpty,
    output logic [BLOCK_W-1:0] rxData,
    input  logic               rxPop,
    output logic [15:0]        blkCount
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    laneT               laneReg;
    logic [BLOCK_W-1:0] asmReg;
    logic [BLOCK_W-1:0] blockNext;
    logic [15:0]        blkCountReg;
    logic [WORD_W-1:0]  wordMasked;
    logic               accept;
    logic               blockDone;
    logic               fifoFull;
    logic [AW:0]        fifoCount;

    assign inReady    = (fifoCount != FULL_COUNT);
    assign accept     = inValid && inReady;
    assign blockDone  = accept && (laneReg == LANE3 || inLast);
    assign wordMasked = inLast ? (inData & keepMask(inKeep)) : inData;
    assign blkCount   = blkCountReg;

    // Lane 0 is the most significant word; bits above the current lane stay zero in asmReg
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gLane
            localparam logic [LANE_W-1:0] SLOT = LANE_W'(LANES - 1 - gi);
            assign blockNext[gi*WORD_W +: WORD_W] =
                (laneReg == SLOT) ? wordMasked : asmReg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            laneReg     <= LANE0;
            asmReg      <= '0;
            blkCountReg <= '0;
        end else if (accept) begin
            if (blockDone) begin
                laneReg     <= LANE0;
                asmReg      <= '0;
                blkCountReg <= blkCountReg + 16'd1;
            end else begin
                laneReg <= laneT'(laneReg + 2'd1);
                asmReg  <= blockNext;
            end
        end
    end

    gcm_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (BLOCK_W)
    ) uFifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (blockDone && !fifoFull),
        .wr_data (blockNext),
        .rd_en   (rxPop),
        .rd_data (rxData),
        .empty   (rxEmpty),
        .full    (fifoFull),
        .count   (fifoCount)
    );

endmodule
